// File: rtl/x_stack_mr.sv
// Multi-region trusted-execution access monitor for the openMSP430 fetch/data buses.
// Flags isolation and atomicity violations, then holds a registered reset until a clean restart.
module x_stack_mr #(
    parameter int                      N_REGIONS       = 2,
    parameter logic [15:0]             RESET_HANDLER   = 16'hFFFE,
    parameter logic [16*N_REGIONS-1:0] CODE_BASE       = {16'hB000, 16'hA000},
    parameter logic [16*N_REGIONS-1:0] CODE_TOP        = {16'hB1FE, 16'hA3FE},
    parameter logic [16*N_REGIONS-1:0] DATA_BASE       = {16'h0600, 16'h0400},
    parameter logic [16*N_REGIONS-1:0] DATA_TOP        = {16'h06FF, 16'h05FF},
    parameter logic [15:0]             SHARED_BASE     = 16'h0230,
    parameter logic [15:0]             SHARED_TOP      = 16'h025F,
    parameter int                      MIN_KILL_CYCLES = 4,
    localparam int                     RW              = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   pc,
    input  logic [15:0]   data_addr,
    input  logic          r_en,
    input  logic          w_en,
    input  logic          irq,
    output logic          reset,
    output logic [2:0]    viol_cause,
    output logic [RW-1:0] viol_region,
    output logic [7:0]    viol_count
);

    localparam int KW = $clog2(MIN_KILL_CYCLES + 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        KILL = 1'b1
    } state_t;

    state_t                 state;
    logic [KW-1:0]          kill_cnt;
    logic [15:0]            prev_pc;
    logic [N_REGIONS-1:0]   prev_in;

    logic [N_REGIONS-1:0]   in_code;
    logic [N_REGIONS-1:0]   in_data;
    logic                   in_shared;
    logic [5*N_REGIONS-1:0] hits;
    logic                   viol;
    logic [2:0]             sel_cause;
    logic [RW-1:0]          sel_region;
    logic                   release_ok;

    // Region membership and the five per-region violation terms; bit 5r+(c-1) is cause c.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_code   = '0;
        in_data   = '0;
        hits      = '0;
        in_shared = (data_addr >= SHARED_BASE) && (data_addr <= SHARED_TOP);
        for (int r = 0; r < N_REGIONS; r++) begin
            in_code[r] = (pc >= CODE_BASE[16*r +: 16]) && (pc <= CODE_TOP[16*r +: 16]);
            in_data[r] = (data_addr >= DATA_BASE[16*r +: 16]) && (data_addr <= DATA_TOP[16*r +: 16]);
        end
        for (int r = 0; r < N_REGIONS; r++) begin
            hits[5*r+0] = (r_en || w_en) && in_data[r] && !in_code[r];
            hits[5*r+1] = in_code[r] && w_en && !in_data[r] && !in_shared;
            hits[5*r+2] = in_code[r] && !prev_in[r] && (pc != CODE_BASE[16*r +: 16]);
            hits[5*r+3] = prev_in[r] && !in_code[r] && (prev_pc != CODE_TOP[16*r +: 16]);
            hits[5*r+4] = in_code[r] && irq;
        end
    end

    // Scan from the least important hit upward so the lowest region, then lowest cause, wins.
    always_comb begin
        viol       = 1'b0;
        sel_cause  = '0;
        sel_region = '0;
        for (int r = N_REGIONS - 1; r >= 0; r--) begin
            for (int c = 5; c >= 1; c--) begin
                if (hits[5*r + c - 1]) begin
                    viol       = 1'b1;
                    sel_cause  = 3'(c);
                    sel_region = RW'(r);
                end
            end
        end
    end

    assign release_ok = (pc == RESET_HANDLER) && !viol && (kill_cnt >= KW'(MIN_KILL_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            reset       <= 1'b0;
            viol_cause  <= '0;
            viol_region <= '0;
            viol_count  <= '0;
            kill_cnt    <= '0;
            prev_pc     <= RESET_HANDLER;
            prev_in     <= '0;
        end else begin
            prev_pc <= pc;
            prev_in <= in_code;
            case (state)
                RUN: begin
                    if (viol) begin
                        state       <= KILL;
                        reset       <= 1'b1;
                        viol_cause  <= sel_cause;
                        viol_region <= sel_region;
                        kill_cnt    <= '0;
                        if (viol_count != 8'hFF) begin
                            viol_count <= viol_count + 8'd1;
                        end
                    end
                end
                KILL: begin
                    // Violations here only veto release; they never touch the recorded cause or counters.
                    if (kill_cnt < KW'(MIN_KILL_CYCLES)) begin
                        kill_cnt <= kill_cnt + 1'b1;
                    end
                    if (release_ok) begin
                        state <= RUN;
                        reset <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_stack_mr.sv
// Self-checking bench for x_stack_mr: single-violation vector table plus
// hand-written sequences for pulse length, release veto, rst priority and count saturation.
module tb_x_stack_mr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc = 16'hC000;
    logic [15:0] data_addr = 16'h0000;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic        irq = 1'b0;
    logic        reset;
    logic [2:0]  viol_cause;
    logic [0:0]  viol_region;
    logic [7:0]  viol_count;

    int checks = 0;
    int errors = 0;

    x_stack_mr dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .data_addr   (data_addr),
        .r_en        (r_en),
        .w_en        (w_en),
        .irq         (irq),
        .reset       (reset),
        .viol_cause  (viol_cause),
        .viol_region (viol_region),
        .viol_count  (viol_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pre0;
        logic [15:0] pre1;
        logic [15:0] pc;
        logic [15:0] addr;
        logic        r_en;
        logic        w_en;
        logic        irq;
        logic        exp_reset;
        logic [2:0]  exp_cause;
        logic        exp_region;
        logic [7:0]  exp_count;
    } vec_t;

    typedef struct {
        string      name;
        logic       exp_reset;
        logic [2:0] exp_cause;
        logic       exp_region;
        logic [7:0] exp_count;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc = 16'hC000; data_addr = 16'h0000; r_en = 1'b0; w_en = 1'b0; irq = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic add(input string n, input logic [15:0] p0, input logic [15:0] p1,
                       input logic [15:0] p, input logic [15:0] a,
                       input logic r, input logic w, input logic i,
                       input logic er, input logic [2:0] ec, input logic eg, input logic [7:0] en);
        vec_t v;
        v.name = n; v.pre0 = p0; v.pre1 = p1; v.pc = p; v.addr = a;
        v.r_en = r; v.w_en = w; v.irq = i;
        v.exp_reset = er; v.exp_cause = ec; v.exp_region = eg; v.exp_count = en;
        vecs.push_back(v);
    endtask

    initial begin
        int   hi;
        bit   inj;
        exp_t e;

        //   name                 pre0      pre1      pc        addr      r  w  i  rst cause reg cnt
        add("foreign_read",      16'hC000, 16'hC000, 16'hC000, 16'h0410, 1, 0, 0, 1, 3'd1, 0, 8'd1);
        add("foreign_read_top",  16'hC000, 16'hC000, 16'hC000, 16'h05FF, 1, 0, 0, 1, 3'd1, 0, 8'd1);
        add("foreign_read_r1",   16'hC000, 16'hC000, 16'hC000, 16'h0600, 1, 0, 0, 1, 3'd1, 1, 8'd1);
        // Region 0's foreign-access term outranks region 1's own write and entry terms.
        add("b010_writes_0420",  16'hC000, 16'hC000, 16'hB010, 16'h0420, 0, 1, 0, 1, 3'd1, 0, 8'd1);
        add("illegal_write",     16'hB000, 16'hB010, 16'hB010, 16'h0300, 0, 1, 0, 1, 3'd2, 1, 8'd1);
        add("shared_write",      16'hB000, 16'hB010, 16'hB010, 16'h0240, 0, 1, 0, 0, 3'd0, 0, 8'd0);
        add("shared_top_write",  16'hB000, 16'hB010, 16'hB010, 16'h025F, 0, 1, 0, 0, 3'd0, 0, 8'd0);
        add("past_shared_write", 16'hB000, 16'hB010, 16'hB010, 16'h0260, 0, 1, 0, 1, 3'd2, 1, 8'd1);
        add("own_data_write",    16'hB000, 16'hB010, 16'hB010, 16'h0610, 0, 1, 0, 0, 3'd0, 0, 8'd0);
        add("illegal_entry",     16'h9FFE, 16'h9FFE, 16'hA002, 16'h0000, 0, 0, 0, 1, 3'd3, 0, 8'd1);
        add("entry_at_base",     16'hC000, 16'hC000, 16'hA000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 8'd0);
        add("entry_r1_mid",      16'hC000, 16'hC000, 16'hB002, 16'h0000, 0, 0, 0, 1, 3'd3, 1, 8'd1);
        add("exit_at_top",       16'hA000, 16'hA3FE, 16'hC000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 8'd0);
        add("illegal_exit",      16'hA000, 16'hA100, 16'hC000, 16'h0000, 0, 0, 0, 1, 3'd4, 0, 8'd1);
        add("irq_trusted",       16'hB000, 16'hB004, 16'hB004, 16'h0000, 0, 0, 1, 1, 3'd5, 1, 8'd1);
        add("irq_untrusted",     16'hC000, 16'hC000, 16'hC000, 16'h0000, 0, 0, 1, 0, 3'd0, 0, 8'd0);

        do_reset();
        check("rst_reset", 16'(reset), 16'd0);
        check("rst_cause", 16'(viol_cause), 16'd0);
        check("rst_region", 16'(viol_region), 16'd0);
        check("rst_count", 16'(viol_count), 16'd0);

        foreach (vecs[k]) begin
            do_reset();
            pc = vecs[k].pre0; step();
            pc = vecs[k].pre1; step();
            pc = vecs[k].pc; data_addr = vecs[k].addr;
            r_en = vecs[k].r_en; w_en = vecs[k].w_en; irq = vecs[k].irq;
            e.name = vecs[k].name; e.exp_reset = vecs[k].exp_reset;
            e.exp_cause = vecs[k].exp_cause; e.exp_region = vecs[k].exp_region;
            e.exp_count = vecs[k].exp_count;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            check({e.name, "_reset"}, 16'(reset), 16'(e.exp_reset));
            check({e.name, "_cause"}, 16'(viol_cause), 16'(e.exp_cause));
            check({e.name, "_region"}, 16'(viol_region), 16'(e.exp_region));
            check({e.name, "_count"}, 16'(viol_count), 16'(e.exp_count));
        end

        // Reset handler present from the first KILL cycle: pulse lasts exactly the minimum.
        do_reset();
        r_en = 1'b1; data_addr = 16'h0410; step();
        r_en = 1'b0; pc = 16'hFFFE;
        hi = reset ? 1 : 0;
        for (int i = 0; i < 20 && reset; i++) begin
            step();
            if (reset) hi++;
        end
        check("hold_pulse_len", 16'(hi), 16'd4);
        check("hold_cause_kept", 16'(viol_cause), 16'd1);
        check("hold_region_kept", 16'(viol_region), 16'd0);
        check("hold_count", 16'(viol_count), 16'd1);

        // A violation in the 4th KILL cycle vetoes that release and leaves the record alone.
        do_reset();
        pc = 16'hB010; w_en = 1'b1; data_addr = 16'h0300; step();
        w_en = 1'b0; pc = 16'hFFFE;
        hi = reset ? 1 : 0;
        inj = 1'b0;
        for (int i = 0; i < 20 && reset; i++) begin
            if (hi == 4 && !inj) begin
                r_en = 1'b1; data_addr = 16'h0410; inj = 1'b1;
            end
            step();
            r_en = 1'b0;
            if (reset) hi++;
        end
        check("extend_pulse_len", 16'(hi), 16'd5);
        check("extend_cause_kept", 16'(viol_cause), 16'd2);
        check("extend_region_kept", 16'(viol_region), 16'd1);
        check("extend_count", 16'(viol_count), 16'd1);

        // rst in the middle of KILL clears everything on the next cycle.
        do_reset();
        r_en = 1'b1; data_addr = 16'h0410; step();
        r_en = 1'b0; pc = 16'hFFFE; step();
        check("midkill_in_kill", 16'(reset), 16'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("midkill_reset", 16'(reset), 16'd0);
        check("midkill_cause", 16'(viol_cause), 16'd0);
        check("midkill_region", 16'(viol_region), 16'd0);
        check("midkill_count", 16'(viol_count), 16'd0);

        // rst coinciding with a violation: no KILL entry and no count.
        do_reset();
        r_en = 1'b1; data_addr = 16'h0410; rst = 1'b1; step();
        rst = 1'b0; r_en = 1'b0;
        check("rst_wins_reset", 16'(reset), 16'd0);
        check("rst_wins_count", 16'(viol_count), 16'd0);

        // 300 separate violations saturate the counter.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            pc = 16'hC000; r_en = 1'b1; data_addr = 16'h0410; step();
            r_en = 1'b0; pc = 16'hFFFE;
            repeat (4) step();
        end
        check("sat_count", 16'(viol_count), 16'd255);
        check("sat_released", 16'(reset), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
